button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//  Upstream front end for the board push-buttons. Feeds the button-driven counter/RAM-read test logic.
//  Synchronises raw KEY inputs and debounces them per button.
//  Emits a clean level plus single-cycle press/release pulses, and an optional hold-to-auto-repeat pulse.
//  The pulses let downstream FSMs advance exactly once per physical press, with no edge tracking of their own.
// PARAMETERS
//  N_BUTTONS        4           number of independent button channels
//  ACTIVE_LOW       1           1: raw input 0 means pressed (board KEYs); 0: raw 1 means pressed
//  DEBOUNCE_CYCLES  500_000     consecutive stable sync samples required to accept a change (10 ms @ 50 MHz); >=1
//  REPEAT_DELAY     25_000_000  cycles held in PRESSED before first btn_repeat; 0 disables auto-repeat
//  REPEAT_RATE      5_000_000   cycles between subsequent btn_repeat pulses; >=1
// PORTS
//  clk          in   1          system clock
//  rst          in   1          synchronous, active-high reset
//  btn_raw      in   N_BUTTONS  asynchronous raw button pins
//  btn_level    out  N_BUTTONS  debounced state, 1 = pressed
//  btn_press    out  N_BUTTONS  1-cycle pulse when level goes 0->1
//  btn_release  out  N_BUTTONS  1-cycle pulse when level goes 1->0
//  btn_repeat   out  N_BUTTONS  1-cycle auto-repeat pulse while held
//  any_press    out  1          OR of btn_press, same cycle
// BEHAVIOUR
//  - Reset: all outputs 0; sync flops load the released value; every channel enters RELEASED; counters = 0.
//  - Input: ACTIVE_LOW inverts btn_raw. A 2-flop synchroniser per bit then produces s (1 = pressed).
//  - Per-channel FSM, all channels independent:
//     RELEASED        : s=1 -> PRESS_PENDING, deb_cnt<=1.
//     PRESS_PENDING   : s=0 -> RELEASED, deb_cnt<=0 (bounce, no pulse).
//                       s=1 and deb_cnt==DEBOUNCE_CYCLES-1 -> PRESSED; btn_press=1 this cycle, btn_level=1 from next.
//                       otherwise deb_cnt++.
//     PRESSED         : s=0 -> RELEASE_PENDING (mirror of PRESS_PENDING). rep_cnt counts while s=1.
//     RELEASE_PENDING : s=1 -> PRESSED; rep_cnt is NOT cleared.
//                       DEBOUNCE_CYCLES stable 0 samples -> RELEASED; btn_release=1, btn_level=0 from next.
//  - DEBOUNCE_CYCLES==1: a change is accepted on its first sync sample.
//  - Latency: a clean step on btn_raw gives the btn_press pulse DEBOUNCE_CYCLES+2 edges after the first edge that samples it.
//  - Pulses (press, release, repeat) are registered outputs and last exactly 1 cycle.
//  - Repeat: on PRESSED entry rep_cnt=0 and first=1.
//     first && rep_cnt==REPEAT_DELAY-1 -> btn_repeat=1, rep_cnt<=0, first<=0.
//     !first && rep_cnt==REPEAT_RATE-1 -> btn_repeat=1, rep_cnt<=0.
//     btn_press and btn_repeat are never high in the same cycle.
//  - Widths: deb_cnt is $clog2(DEBOUNCE_CYCLES+1) bits. rep_cnt is $clog2(max(REPEAT_DELAY,REPEAT_RATE)+1) bits.
//    Counters saturate and never wrap.
//  - Simultaneous events: channels are independent, so several press pulses may coincide; any_press ORs them.
//  - Reset mid-operation: pending/held state is discarded.
//    A button still held when rst releases is re-debounced and produces one fresh btn_press.
//  - No combinational path from btn_raw to any output.
// STRUCTURE
//  - Package button_pkg: typedef enum logic [1:0] btn_state_t {RELEASED, PRESS_PENDING, PRESSED, RELEASE_PENDING}.
//  - Sub-module button_channel: one synchroniser, FSM, deb_cnt and rep_cnt.
//    Instantiated N_BUTTONS times via generate. The top adds input polarity and any_press only.
// TESTING  (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, ACTIVE_LOW=1)
//  1. rst high 3 cycles -> all outputs 0. btn_raw[0] 1->0 held -> btn_press[0] pulses once at edge 6; btn_level[0]=1 after.
//  2. btn_raw[1] toggles every 2 cycles for 40 cycles -> btn_press[1]/btn_release[1] never assert, btn_level[1] stays 0.
//  3. Hold btn_raw[2]=0 for 30 cycles after press -> btn_repeat[2] pulses 10 cycles after press, then every 3; never with btn_press.
//  4. Release after stable press -> btn_release pulses once at 4+2 edges after the rise; 2-cycle release glitch -> no release pulse.
//  5. Press buttons 0 and 3 on the same edge -> both btn_press bits pulse together; any_press=1 for exactly 1 cycle.
//  6. Assert rst for 1 cycle while button 0 is held in PRESSED -> outputs clear; one new btn_press 6 edges after rst drops.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and helpers for the push-button conditioning front end.
// Channel FSM states plus a constant-foldable max used for counter sizing.
package button_pkg;

   typedef enum logic [1:0] {
      RELEASED        = 2'd0,
      PRESS_PENDING   = 2'd1,
      PRESSED         = 2'd2,
      RELEASE_PENDING = 2'd3
   } btn_state_t;

   function automatic int max_int(input int a, input int b);
      if (a > b) begin
         max_int = a;
      end else begin
         max_int = b;
      end
   endfunction

endpackage

// File: rtl/button_channel.sv
// One button lane: 2-flop synchroniser, debounce FSM and auto-repeat timer.
// All pulse and level outputs are registered; press_set exposes the press pulse's next value.
module button_channel
   import button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500_000,
   parameter int REPEAT_DELAY    = 25_000_000,
   parameter int REPEAT_RATE     = 5_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic pressed_async,
   output logic btn_level,
   output logic btn_press,
   output logic btn_release,
   output logic btn_repeat,
   output logic press_set
);

   localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int REP_W = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);

   localparam logic [DEB_W-1:0] DEB_ZERO  = {DEB_W{1'b0}};
   localparam logic [DEB_W-1:0] DEB_ONE   = DEB_W'(1);
   localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DEB_W-1:0] DEB_SAT   = {DEB_W{1'b1}};

   localparam bit SINGLE_SAMPLE = (DEBOUNCE_CYCLES == 1);
   localparam bit REPEAT_EN     = (REPEAT_DELAY > 0);

   localparam logic [REP_W-1:0] REP_ZERO   = {REP_W{1'b0}};
   localparam logic [REP_W-1:0] REP_ONE    = REP_W'(1);
   localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REPEAT_EN ? REPEAT_DELAY - 1 : 0);
   localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(REPEAT_RATE - 1);
   localparam logic [REP_W-1:0] REP_SAT    = {REP_W{1'b1}};

   function automatic logic [DEB_W-1:0] deb_inc(input logic [DEB_W-1:0] v);
      if (v == DEB_SAT) begin
         deb_inc = v;
      end else begin
         deb_inc = v + DEB_ONE;
      end
   endfunction

   function automatic logic [REP_W-1:0] rep_inc(input logic [REP_W-1:0] v);
      if (v == REP_SAT) begin
         rep_inc = v;
      end else begin
         rep_inc = v + REP_ONE;
      end
   endfunction

   logic             sync_meta_r;
   logic             sync_r;
   btn_state_t       state_r;
   btn_state_t       state_nxt_s;
   logic [DEB_W-1:0] deb_cnt_r;
   logic [DEB_W-1:0] deb_cnt_nxt_s;
   logic [REP_W-1:0] rep_cnt_r;
   logic [REP_W-1:0] rep_cnt_nxt_s;
   logic             first_r;
   logic             first_nxt_s;
   logic             press_nxt_s;
   logic             release_nxt_s;
   logic             repeat_nxt_s;
   logic             level_nxt_s;

   // Synchroniser: reset loads the released value so a held key is re-debounced.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_meta_r <= 1'b0;
         sync_r      <= 1'b0;
      end else begin
         sync_meta_r <= pressed_async;
         sync_r      <= sync_meta_r;
      end
   end

   // Next-state, counter and pulse decode for the debounce/repeat FSM.
   always_comb begin
      state_nxt_s   = state_r;
      deb_cnt_nxt_s = deb_cnt_r;
      rep_cnt_nxt_s = rep_cnt_r;
      first_nxt_s   = first_r;
      press_nxt_s   = 1'b0;
      release_nxt_s = 1'b0;
      repeat_nxt_s  = 1'b0;
      case (state_r)
         RELEASED: begin
            if (!sync_r) begin
               deb_cnt_nxt_s = DEB_ZERO;
            end else if (SINGLE_SAMPLE) begin
               state_nxt_s   = PRESSED;
               press_nxt_s   = 1'b1;
               deb_cnt_nxt_s = DEB_ZERO;
               rep_cnt_nxt_s = REP_ZERO;
               first_nxt_s   = 1'b1;
            end else begin
               state_nxt_s   = PRESS_PENDING;
               deb_cnt_nxt_s = DEB_ONE;
            end
         end
         PRESS_PENDING: begin
            if (!sync_r) begin
               state_nxt_s   = RELEASED;
               deb_cnt_nxt_s = DEB_ZERO;
            end else if (deb_cnt_r == DEB_LAST) begin
               state_nxt_s   = PRESSED;
               press_nxt_s   = 1'b1;
               deb_cnt_nxt_s = DEB_ZERO;
               rep_cnt_nxt_s = REP_ZERO;
               first_nxt_s   = 1'b1;
            end else begin
               deb_cnt_nxt_s = deb_inc(deb_cnt_r);
            end
         end
         PRESSED: begin
            if (!sync_r) begin
               if (SINGLE_SAMPLE) begin
                  state_nxt_s   = RELEASED;
                  release_nxt_s = 1'b1;
                  deb_cnt_nxt_s = DEB_ZERO;
               end else begin
                  state_nxt_s   = RELEASE_PENDING;
                  deb_cnt_nxt_s = DEB_ONE;
               end
            end else if (!REPEAT_EN) begin
               rep_cnt_nxt_s = rep_cnt_r;
            end else if (first_r && (rep_cnt_r == DELAY_LAST)) begin
               repeat_nxt_s  = 1'b1;
               rep_cnt_nxt_s = REP_ZERO;
               first_nxt_s   = 1'b0;
            end else if (!first_r && (rep_cnt_r == RATE_LAST)) begin
               repeat_nxt_s  = 1'b1;
               rep_cnt_nxt_s = REP_ZERO;
            end else begin
               rep_cnt_nxt_s = rep_inc(rep_cnt_r);
            end
         end
         RELEASE_PENDING: begin
            // A bounce back to pressed keeps the repeat timer running where it was.
            if (sync_r) begin
               state_nxt_s   = PRESSED;
               deb_cnt_nxt_s = DEB_ZERO;
            end else if (deb_cnt_r == DEB_LAST) begin
               state_nxt_s   = RELEASED;
               release_nxt_s = 1'b1;
               deb_cnt_nxt_s = DEB_ZERO;
            end else begin
               deb_cnt_nxt_s = deb_inc(deb_cnt_r);
            end
         end
         default: begin
            state_nxt_s   = RELEASED;
            deb_cnt_nxt_s = DEB_ZERO;
            rep_cnt_nxt_s = REP_ZERO;
            first_nxt_s   = 1'b0;
         end
      endcase
      level_nxt_s = (state_nxt_s == PRESSED) || (state_nxt_s == RELEASE_PENDING);
   end

   // FSM state, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= RELEASED;
         deb_cnt_r   <= DEB_ZERO;
         rep_cnt_r   <= REP_ZERO;
         first_r     <= 1'b0;
         btn_level   <= 1'b0;
         btn_press   <= 1'b0;
         btn_release <= 1'b0;
         btn_repeat  <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         deb_cnt_r   <= deb_cnt_nxt_s;
         rep_cnt_r   <= rep_cnt_nxt_s;
         first_r     <= first_nxt_s;
         btn_level   <= level_nxt_s;
         btn_press   <= press_nxt_s;
         btn_release <= release_nxt_s;
         btn_repeat  <= repeat_nxt_s;
      end
   end

   assign press_set = press_nxt_s;

endmodule

// File: rtl/button_conditioner.sv
// Push-button front end: polarity fix-up, per-key conditioning channels, and any_press.
// any_press is registered from the channels' next press values so it aligns with btn_press.
module button_conditioner
   import button_pkg::*;
#(
   parameter int N_BUTTONS       = 4,
   parameter int ACTIVE_LOW      = 1,
   parameter int DEBOUNCE_CYCLES = 500_000,
   parameter int REPEAT_DELAY    = 25_000_000,
   parameter int REPEAT_RATE     = 5_000_000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_BUTTONS-1:0] btn_raw,
   output logic [N_BUTTONS-1:0] btn_level,
   output logic [N_BUTTONS-1:0] btn_press,
   output logic [N_BUTTONS-1:0] btn_release,
   output logic [N_BUTTONS-1:0] btn_repeat,
   output logic                 any_press
);

   logic [N_BUTTONS-1:0] pressed_s;
   logic [N_BUTTONS-1:0] press_set_s;

   // Normalise raw pin polarity so 1 always means pressed.
   always_comb begin
      if (ACTIVE_LOW != 0) begin
         pressed_s = ~btn_raw;
      end else begin
         pressed_s = btn_raw;
      end
   end

   for (genvar i = 0; i < N_BUTTONS; i++) begin : g_chan
      button_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_RATE     (REPEAT_RATE)
      ) u_chan (
         .clk           (clk),
         .rst           (rst),
         .pressed_async (pressed_s[i]),
         .btn_level     (btn_level[i]),
         .btn_press     (btn_press[i]),
         .btn_release   (btn_release[i]),
         .btn_repeat    (btn_repeat[i]),
         .press_set     (press_set_s[i])
      );
   end

   // Registered OR of all channel press pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         any_press <= 1'b0;
      end else begin
         any_press <= |press_set_s;
      end
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3.
// Edge t=1 is the first clock edge that samples a new btn_raw value; outputs are checked 1 ns after each edge.
module tb_button_conditioner;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] btn_raw;
   logic [3:0] btn_level;
   logic [3:0] btn_press;
   logic [3:0] btn_release;
   logic [3:0] btn_repeat;
   logic       any_press;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   button_conditioner #(
      .N_BUTTONS       (4),
      .ACTIVE_LOW      (1),
      .DEBOUNCE_CYCLES (4),
      .REPEAT_DELAY    (10),
      .REPEAT_RATE     (3)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_raw     (btn_raw),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release),
      .btn_repeat  (btn_repeat),
      .any_press   (any_press)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic test_reset();
      rst     = 1'b1;
      btn_raw = 4'hF;
      for (int t = 1; t <= 5; t++) begin
         if (t == 4) rst = 1'b0;
         tick();
         n_cmp++;
         if ({btn_level, btn_press, btn_release, btn_repeat, any_press} !== 17'd0) begin
            n_err++;
            $display("FAIL reset_outputs t=%0d got %h exp 0", t,
                     {btn_level, btn_press, btn_release, btn_repeat, any_press});
         end
      end
   endtask

   task automatic test_press();
      btn_raw[0] = 1'b0;
      for (int t = 1; t <= 8; t++) begin
         tick();
         n_cmp++;
         if (btn_press[0] !== (t == 6)) begin
            n_err++;
            $display("FAIL press0 t=%0d got %b exp %b", t, btn_press[0], (t == 6));
         end
         n_cmp++;
         if (any_press !== (t == 6)) begin
            n_err++;
            $display("FAIL any_press t=%0d got %b exp %b", t, any_press, (t == 6));
         end
         if (t != 6) begin
            n_cmp++;
            if (btn_level[0] !== (t > 6)) begin
               n_err++;
               $display("FAIL level0_press t=%0d got %b exp %b", t, btn_level[0], (t > 6));
            end
         end
      end
   endtask

   task automatic test_release();
      btn_raw[0] = 1'b1;
      for (int t = 1; t <= 8; t++) begin
         tick();
         n_cmp++;
         if (btn_release[0] !== (t == 6)) begin
            n_err++;
            $display("FAIL release0 t=%0d got %b exp %b", t, btn_release[0], (t == 6));
         end
         if (t != 6) begin
            n_cmp++;
            if (btn_level[0] !== (t < 6)) begin
               n_err++;
               $display("FAIL level0_release t=%0d got %b exp %b", t, btn_level[0], (t < 6));
            end
         end
      end
   endtask

   task automatic test_release_glitch();
      btn_raw[0] = 1'b0;
      idle(10);
      for (int t = 1; t <= 14; t++) begin
         btn_raw[0] = (t <= 2) ? 1'b1 : 1'b0;
         tick();
         n_cmp++;
         if ({btn_release[0], btn_level[0]} !== 2'b01) begin
            n_err++;
            $display("FAIL release_glitch t=%0d got rel=%b lvl=%b exp rel=0 lvl=1",
                     t, btn_release[0], btn_level[0]);
         end
      end
      btn_raw[0] = 1'b1;
      idle(10);
   endtask

   task automatic test_bounce();
      for (int c = 0; c < 48; c++) begin
         btn_raw[1] = (c >= 40) ? 1'b1 : (((c / 2) % 2) != 0);
         tick();
         n_cmp++;
         if ({btn_press[1], btn_release[1], btn_level[1]} !== 3'b000) begin
            n_err++;
            $display("FAIL bounce1 c=%0d got p=%b r=%b l=%b exp 000",
                     c, btn_press[1], btn_release[1], btn_level[1]);
         end
      end
   endtask

   task automatic test_repeat();
      logic exp_rep;
      btn_raw[2] = 1'b0;
      for (int t = 1; t <= 40; t++) begin
         tick();
         exp_rep = (t >= 16) && (((t - 16) % 3) == 0);
         n_cmp++;
         if (btn_press[2] !== (t == 6)) begin
            n_err++;
            $display("FAIL press2 t=%0d got %b exp %b", t, btn_press[2], (t == 6));
         end
         n_cmp++;
         if (btn_repeat[2] !== exp_rep) begin
            n_err++;
            $display("FAIL repeat2 t=%0d got %b exp %b", t, btn_repeat[2], exp_rep);
         end
      end
      btn_raw[2] = 1'b1;
      idle(12);
   endtask

   task automatic test_simultaneous();
      btn_raw = 4'b0110;
      for (int t = 1; t <= 8; t++) begin
         tick();
         n_cmp++;
         if (btn_press !== ((t == 6) ? 4'b1001 : 4'b0000)) begin
            n_err++;
            $display("FAIL press_both t=%0d got %b exp %b", t, btn_press,
                     ((t == 6) ? 4'b1001 : 4'b0000));
         end
         n_cmp++;
         if (any_press !== (t == 6)) begin
            n_err++;
            $display("FAIL any_press_both t=%0d got %b exp %b", t, any_press, (t == 6));
         end
      end
      btn_raw = 4'hF;
      idle(12);
   endtask

   task automatic test_reset_mid();
      btn_raw[0] = 1'b0;
      idle(10);
      n_cmp++;
      if (btn_level[0] !== 1'b1) begin
         n_err++;
         $display("FAIL held_before_rst got %b exp 1", btn_level[0]);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++;
      if ({btn_level, btn_press, btn_release, btn_repeat, any_press} !== 17'd0) begin
         n_err++;
         $display("FAIL mid_reset_clear got %h exp 0",
                  {btn_level, btn_press, btn_release, btn_repeat, any_press});
      end
      for (int t = 1; t <= 8; t++) begin
         tick();
         n_cmp++;
         if (btn_press[0] !== (t == 6)) begin
            n_err++;
            $display("FAIL repress0 t=%0d got %b exp %b", t, btn_press[0], (t == 6));
         end
         if (t != 6) begin
            n_cmp++;
            if (btn_level[0] !== (t > 6)) begin
               n_err++;
               $display("FAIL relevel0 t=%0d got %b exp %b", t, btn_level[0], (t > 6));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_press();
      test_release();
      test_release_glitch();
      test_bounce();
      test_repeat();
      test_simultaneous();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
